// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard sources and pipeline register controls for pipeline_hazard_ctrl
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_MemRead;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_flush;
  logic [1:0]       state;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_MemRead,
           ex_redirect, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_flush, state, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_MemRead,
           ex_redirect, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_flush, state, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage stall/flush sequencer: load-use bubble, redirect flush, memory freeze, watchdog
// PIPE_CTRL_PERF_EN builds the saturating stall/flush counters; otherwise they read 0.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2,
    REDIRECT  = 2'd3
  } state_e;

  localparam int WW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_timeout_q, mem_timeout_d;

  logic lu, mw;
  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c, exmem_en_c, memwb_flush_c;

  always_comb begin
    lu = hz.ex_MemRead && (hz.ex_rd != 5'd0) &&
         ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
          (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    // The instruction in ID has already been bubbled or flushed once; never stall it again.
    if (state_q == LU_BUBBLE || state_q == REDIRECT) lu = 1'b0;
    mw = hz.mem_req && !hz.mem_ready;

    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_en_c     = 1'b1;
    idex_flush_c  = 1'b0;
    exmem_en_c    = 1'b1;
    memwb_flush_c = 1'b0;
    state_d       = RUN;

    if (mw) begin
      pc_en_c       = 1'b0;
      ifid_en_c     = 1'b0;
      idex_en_c     = 1'b0;
      exmem_en_c    = 1'b0;
      memwb_flush_c = 1'b1;
      state_d       = MEM_WAIT;
    end else if (hz.ex_redirect) begin
      ifid_flush_c  = 1'b1;
      idex_flush_c  = 1'b1;
      state_d       = REDIRECT;
    end else if (lu) begin
      pc_en_c       = 1'b0;
      ifid_en_c     = 1'b0;
      idex_flush_c  = 1'b1;
      state_d       = LU_BUBBLE;
    end

    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (state_q == MEM_WAIT) begin
      if (wait_cnt_q == WAIT_LAST) mem_timeout_d = 1'b1;
      else                         wait_cnt_d    = wait_cnt_q + WW'(1);
    end
    if (state_d == MEM_WAIT && state_q != MEM_WAIT) wait_cnt_d = '0;

    if (!reset) begin
      pc_en_c       = 1'b0;
      ifid_en_c     = 1'b0;
      idex_en_c     = 1'b0;
      exmem_en_c    = 1'b0;
      ifid_flush_c  = 1'b1;
      idex_flush_c  = 1'b1;
      memwb_flush_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             redirect_svc;

  always_comb begin
    redirect_svc = hz.ex_redirect && !mw;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!pc_en_c && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect_svc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

  assign hz.pc_en       = pc_en_c;
  assign hz.ifid_en     = ifid_en_c;
  assign hz.ifid_flush  = ifid_flush_c;
  assign hz.idex_en     = idex_en_c;
  assign hz.idex_flush  = idex_flush_c;
  assign hz.exmem_en    = exmem_en_c;
  assign hz.memwb_flush = memwb_flush_c;
  assign hz.state       = state_q;
  assign hz.mem_timeout = mem_timeout_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl with a cycle-level reference model
module tb_pipeline_hazard_ctrl;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 16;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
    logic             chk_regs;
    logic [1:0]       state;
    logic             timeout;
    logic [CNT_W-1:0] stall, flush;
  } exp_t;

  exp_t sb[$];

  // Reference state: plain integers tracking what the pipeline controller should remember.
  int m_state;
  int m_wait;
  bit m_timeout;
  int m_stall;
  int m_flush;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input bit rst_n, input int rs1, input int rs2, input bit u1, input bit u2,
                     input int rd, input bit mr, input bit redir, input bit mreq, input bit mrdy);
    exp_t e;
    int   srcs[$];
    bit   lu, mw;
    int   nxt;
    @(posedge clk);
    #1;
    reset          = rst_n;
    hz.id_rs1      = 5'(rs1);
    hz.id_rs2      = 5'(rs2);
    hz.id_use_rs1  = u1;
    hz.id_use_rs2  = u2;
    hz.ex_rd       = 5'(rd);
    hz.ex_MemRead  = mr;
    hz.ex_redirect = redir;
    hz.mem_req     = mreq;
    hz.mem_ready   = mrdy;

    if (u1) srcs.push_back(rs1);
    if (u2) srcs.push_back(rs2);
    lu = 1'b0;
    if (mr && rd != 0) foreach (srcs[i]) if (srcs[i] == rd) lu = 1'b1;
    if (m_state == 1 || m_state == 3) lu = 1'b0;
    mw = mreq && !mrdy;

    e.chk_regs = rst_n;
    e.state    = 2'(m_state);
    e.timeout  = m_timeout;
    e.stall    = PERF ? CNT_W'(m_stall) : '0;
    e.flush    = PERF ? CNT_W'(m_flush) : '0;

    if (!rst_n) begin
      {e.pc_en, e.ifid_en, e.idex_en, e.exmem_en} = 4'b0000;
      {e.ifid_flush, e.idex_flush, e.memwb_flush} = 3'b111;
      m_state = 0; m_wait = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      {e.pc_en, e.ifid_en, e.idex_en, e.exmem_en} = 4'b1111;
      {e.ifid_flush, e.idex_flush, e.memwb_flush} = 3'b000;
      if (mw) begin
        {e.pc_en, e.ifid_en, e.idex_en, e.exmem_en} = 4'b0000;
        e.memwb_flush = 1'b1;
        nxt = 2;
      end else if (redir) begin
        e.ifid_flush = 1'b1;
        e.idex_flush = 1'b1;
        if (m_flush < (1 << CNT_W) - 1) m_flush++;
        nxt = 3;
      end else if (lu) begin
        e.pc_en      = 1'b0;
        e.ifid_en    = 1'b0;
        e.idex_flush = 1'b1;
        nxt = 1;
      end else begin
        nxt = 0;
      end
      if (!e.pc_en && m_stall < (1 << CNT_W) - 1) m_stall++;
      if (m_state == 2) begin
        m_wait++;
        if (m_wait >= MAX_WAIT) m_timeout = 1'b1;
      end
      if (nxt == 2 && m_state != 2) m_wait = 0;
      m_state = nxt;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("pc_en",       hz.pc_en,       e.pc_en);
      chk("ifid_en",     hz.ifid_en,     e.ifid_en);
      chk("ifid_flush",  hz.ifid_flush,  e.ifid_flush);
      chk("idex_en",     hz.idex_en,     e.idex_en);
      chk("idex_flush",  hz.idex_flush,  e.idex_flush);
      chk("exmem_en",    hz.exmem_en,    e.exmem_en);
      chk("memwb_flush", hz.memwb_flush, e.memwb_flush);
      if (e.chk_regs) begin
        chk("state",       hz.state,       e.state);
        chk("mem_timeout", hz.mem_timeout, e.timeout);
        chk("stall_cnt",   hz.stall_cnt,   e.stall);
        chk("flush_cnt",   hz.flush_cnt,   e.flush);
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    m_state = 0; m_wait = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0;
    reset = 1'b0;
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd = '0; hz.ex_MemRead = 1'b0; hz.ex_redirect = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;

    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // load-use, then held inputs in LU_BUBBLE, then ex_rd = 0
    drv(1, 5, 1, 1, 1, 5, 1, 0, 0, 0);
    drv(1, 5, 1, 1, 1, 5, 1, 0, 0, 0);
    idle(1);
    drv(1, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    idle(1);

    // redirect followed by a masked load-use match
    drv(1, 5, 0, 1, 0, 7, 0, 1, 0, 0);
    drv(1, 5, 0, 1, 0, 5, 1, 0, 0, 0);
    idle(1);

    // memory wait of three frozen cycles
    repeat (3) drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // mw + redirect + lu together, released by mem_ready
    repeat (2) drv(1, 3, 0, 1, 0, 3, 1, 1, 1, 0);
    drv(1, 3, 0, 1, 0, 3, 1, 1, 1, 1);
    drv(1, 3, 0, 1, 0, 3, 1, 0, 0, 0);
    idle(1);

    // watchdog
    repeat (6) drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);

    // reset mid MEM_WAIT
    repeat (2) drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      drv(($urandom_range(0, 99) >= 2),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
          ($urandom_range(0, 99) < 20),
          ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 40));
    end
    idle(2);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
